// File: rtl/invl_stats_ctr_bank.sv
// Bank of interval statistics counters: live per-channel accumulators with saturate/wrap policy,
// snapshotted into shadow registers on each interval boundary and read through a registered port.
module invl_stats_ctr_bank #(
    parameter int NUM_CTR  = 8,
    parameter int SIZE     = 32,
    parameter int INC_W    = 4,
    parameter int SATURATE = 1,
    parameter int SEQ_W    = 16,
    localparam int IDX_W   = (NUM_CTR > 1) ? $clog2(NUM_CTR) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     latch_clr,
    input  logic [NUM_CTR-1:0]       inc_vld,
    input  logic [NUM_CTR*INC_W-1:0] inc_val,
    input  logic                     rd_en,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [SIZE-1:0]          rd_data,
    output logic                     rd_ovfl,
    output logic                     rd_vld,
    output logic [SEQ_W-1:0]         invl_seq_r,
    output logic                     latch_done
);

    logic [SIZE-1:0] ctr     [NUM_CTR];
    logic [SIZE-1:0] ctr_nxt [NUM_CTR];
    logic [SIZE-1:0] lat     [NUM_CTR];
    logic [NUM_CTR-1:0] ovf;
    logic [NUM_CTR-1:0] ovf_hit;
    logic [NUM_CTR-1:0] lat_ovf;

    for (genvar i = 0; i < NUM_CTR; i++) begin : g_ch
        logic [INC_W-1:0] inc;
        logic [SIZE:0]    sum;

        assign inc = inc_val[i*INC_W +: INC_W];

        // One extra bit on the adder exposes the carry-out that defines overflow.
        always_comb begin
            sum        = {1'b0, ctr[i]} + {{(SIZE+1-INC_W){1'b0}}, inc};
            ovf_hit[i] = 1'b0;
            ctr_nxt[i] = ctr[i];
            if (inc_vld[i]) begin
                ovf_hit[i] = sum[SIZE];
                if (sum[SIZE] && (SATURATE != 0))
                    ctr_nxt[i] = '1;
                else
                    ctr_nxt[i] = sum[SIZE-1:0];
            end
        end

        // NOTE: the shadow array is reset as well so a read before the first snapshot returns 0;
        // this keeps it in flops rather than a RAM macro, which is fine at this size.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ctr[i]     <= '0;
                ovf[i]     <= 1'b0;
                lat[i]     <= '0;
                lat_ovf[i] <= 1'b0;
            end else if (latch_clr) begin
                // Snapshot uses pre-edge values; this cycle's increment seeds the new interval.
                lat[i]     <= ctr[i];
                lat_ovf[i] <= ovf[i];
                ctr[i]     <= inc_vld[i] ? {{(SIZE-INC_W){1'b0}}, inc} : '0;
                ovf[i]     <= 1'b0;
            end else begin
                ctr[i] <= ctr_nxt[i];
                ovf[i] <= ovf[i] | ovf_hit[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            invl_seq_r <= '0;
            latch_done <= 1'b0;
        end else begin
            latch_done <= latch_clr;
            if (latch_clr)
                invl_seq_r <= invl_seq_r + 1'b1;
        end
    end

    // Read port samples the shadow array before any same-edge snapshot lands, so a read
    // coinciding with latch_clr sees the previous interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_ovfl <= 1'b0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en) begin
                if ({{(32-IDX_W){1'b0}}, rd_idx} < NUM_CTR) begin
                    rd_data <= lat[rd_idx];
                    rd_ovfl <= lat_ovf[rd_idx];
                end else begin
                    rd_data <= '0;
                    rd_ovfl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_invl_stats_ctr_bank.sv
// Directed self-checking bench: one default-sized bank plus two 8-bit banks (saturate and wrap)
// driven from shared stimulus, each checked against hand-computed values.
module tb_invl_stats_ctr_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        latch_clr;
    logic [7:0]  inc_vld;
    logic [31:0] inc_val;
    logic        rd_en;
    logic [2:0]  rd_idx;

    logic [31:0] m_data;
    logic        m_ovfl, m_vld, m_done;
    logic [15:0] m_seq;

    logic [7:0]  s_data;
    logic        s_ovfl, s_vld, s_done;
    logic [1:0]  s_seq;

    logic [7:0]  w_data;
    logic        w_ovfl, w_vld, w_done;
    logic [1:0]  w_seq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    invl_stats_ctr_bank u_main (
        .clk(clk), .rst_n(rst_n), .latch_clr(latch_clr),
        .inc_vld(inc_vld), .inc_val(inc_val),
        .rd_en(rd_en), .rd_idx(rd_idx),
        .rd_data(m_data), .rd_ovfl(m_ovfl), .rd_vld(m_vld),
        .invl_seq_r(m_seq), .latch_done(m_done)
    );

    invl_stats_ctr_bank #(.NUM_CTR(6), .SIZE(8), .INC_W(4), .SATURATE(1), .SEQ_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .latch_clr(latch_clr),
        .inc_vld(inc_vld[5:0]), .inc_val(inc_val[23:0]),
        .rd_en(rd_en), .rd_idx(rd_idx),
        .rd_data(s_data), .rd_ovfl(s_ovfl), .rd_vld(s_vld),
        .invl_seq_r(s_seq), .latch_done(s_done)
    );

    invl_stats_ctr_bank #(.NUM_CTR(6), .SIZE(8), .INC_W(4), .SATURATE(0), .SEQ_W(2)) u_wrap (
        .clk(clk), .rst_n(rst_n), .latch_clr(latch_clr),
        .inc_vld(inc_vld[5:0]), .inc_val(inc_val[23:0]),
        .rd_en(rd_en), .rd_idx(rd_idx),
        .rd_data(w_data), .rd_ovfl(w_ovfl), .rd_vld(w_vld),
        .invl_seq_r(w_seq), .latch_done(w_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inc(input int ch, input logic [3:0] val);
        inc_vld[ch]        = 1'b1;
        inc_val[ch*4 +: 4] = val;
    endtask

    task automatic clr_inc();
        inc_vld = '0;
        inc_val = '0;
    endtask

    task automatic do_read(input logic [2:0] idx);
        rd_idx = idx;
        rd_en  = 1'b1;
        tick();
        rd_en  = 1'b0;
    endtask

    task automatic do_latch();
        latch_clr = 1'b1;
        tick();
        latch_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; latch_clr = 1'b0; rd_en = 1'b0; rd_idx = '0;
        inc_vld = '0; inc_val = '0;
        #22 rst_n = 1'b1;
        tick();

        // Reset state: every shadow reads 0, sequence at 0.
        check("reset_seq", m_seq, 0);
        check("reset_done", m_done, 0);
        for (int i = 0; i < 8; i++) begin
            do_read(3'(i));
            check($sformatf("reset_rd_data%0d", i), m_data, 0);
            check($sformatf("reset_rd_ovfl%0d", i), m_ovfl, 0);
            check($sformatf("reset_rd_vld%0d", i), m_vld, 1);
        end

        // Ch 3: 10 x 5, then latch while ch 3 presents 7.
        set_inc(3, 4'd5);
        repeat (10) tick();
        set_inc(3, 4'd7);
        latch_clr = 1'b1;
        tick();
        latch_clr = 1'b0;
        clr_inc();
        check("latch_done_pulse", m_done, 1);
        check("seq_after_1", m_seq, 1);
        tick();
        check("latch_done_low", m_done, 0);
        do_read(3'd3);
        check("ch3_snapshot", m_data, 50);
        check("ch3_ovfl", m_ovfl, 0);
        check("ch3_snapshot_small", s_data, 50);
        do_latch();
        do_read(3'd3);
        check("ch3_carried_inc", m_data, 7);
        check("seq_after_2", m_seq, 2);

        // Ch 0: 30 x 10 = 300; ch 1: 26 x 10 = 260 (i.e. 250 followed by 10).
        for (int c = 0; c < 30; c++) begin
            clr_inc();
            set_inc(0, 4'd10);
            if (c < 26) set_inc(1, 4'd10);
            tick();
        end
        clr_inc();
        do_latch();
        do_read(3'd0);
        check("main_ch0", m_data, 300);
        check("main_ch0_ovfl", m_ovfl, 0);
        check("sat_ch0", s_data, 255);
        check("sat_ch0_ovfl", s_ovfl, 1);
        check("wrap_ch0", w_data, 44);
        check("wrap_ch0_ovfl", w_ovfl, 1);
        do_read(3'd1);
        check("main_ch1", m_data, 260);
        check("sat_ch1", s_data, 255);
        check("sat_ch1_ovfl", s_ovfl, 1);
        check("wrap_ch1", w_data, 4);
        check("wrap_ch1_ovfl", w_ovfl, 1);
        check("small_seq_3", s_seq, 3);

        // Empty interval clears the sticky flag; 2-bit sequence wraps 3 -> 0.
        do_latch();
        do_read(3'd0);
        check("sat_ch0_idle", s_data, 0);
        check("sat_ch0_idle_ovfl", s_ovfl, 0);
        check("wrap_ch0_idle_ovfl", w_ovfl, 0);
        check("small_seq_wrap", s_seq, 0);
        check("main_seq_4", m_seq, 4);

        // Ch 2: snapshot 6, then 4 pending; read coinciding with latch sees 6, next read sees 4.
        set_inc(2, 4'd3);
        repeat (2) tick();
        clr_inc();
        do_latch();
        set_inc(2, 4'd4);
        tick();
        clr_inc();
        latch_clr = 1'b1;
        rd_en     = 1'b1;
        rd_idx    = 3'd2;
        tick();
        latch_clr = 1'b0;
        check("rd_same_cycle_old", m_data, 6);
        tick();
        rd_en = 1'b0;
        check("rd_next_cycle_new", m_data, 4);
        check("rd_next_vld", m_vld, 1);
        tick();
        check("rd_vld_low", m_vld, 0);
        check("rd_data_hold", m_data, 4);

        // Out-of-range index on the 6-channel banks.
        do_read(3'd6);
        check("oor6_data", s_data, 0);
        check("oor6_ovfl", s_ovfl, 0);
        check("oor6_vld", s_vld, 1);
        do_read(3'd7);
        check("oor7_data", w_data, 0);
        check("oor7_vld", w_vld, 1);

        // Reset mid-interval discards pending counts.
        set_inc(3, 4'd9);
        repeat (3) tick();
        clr_inc();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        check("rst_seq", m_seq, 0);
        check("rst_small_seq", s_seq, 0);
        do_read(3'd2);
        check("rst_shadow", m_data, 0);
        do_latch();
        do_read(3'd3);
        check("rst_discard", m_data, 0);
        check("rst_discard_ovfl", m_ovfl, 0);

        // Four back-to-back strobes: latch_done high every cycle; 5 latches total.
        latch_clr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("b2b_done%0d", k), m_done, 1);
        end
        latch_clr = 1'b0;
        tick();
        check("b2b_done_low", m_done, 0);
        check("seq5_main", m_seq, 5);
        check("seq5_small", s_seq, 1);
        check("seq5_wrap_bank", w_seq, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
